// File: rtl/bc_pkg.sv
// Shared types, widths and the code-legality helper for the Bulls-and-Cows controller.
package bc_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned CODE_W  = 16;
   localparam int unsigned SCORE_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_SCORE = 3'd2,
      ST_WIN   = 3'd3,
      ST_LOSE  = 3'd4
   } state_t;

   // A code is legal when every digit is BCD (0..9) and no digit repeats.
   function automatic logic code_legal(input logic [CODE_W-1:0] code);
      logic               ok;
      logic [DIGIT_W-1:0] di;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         di = code[DIGIT_W*i +: DIGIT_W];
         if (di > 4'd9) ok = 1'b0;
         for (int j = i + 1; j < 4; j++) begin
            if (di == code[DIGIT_W*j +: DIGIT_W]) ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/bc_score.sv
// Combinational strike/ball scorer for two 4-digit BCD codes.
module bc_score
   import bc_pkg::*;
(
   input  logic [CODE_W-1:0]  guess,
   input  logic [CODE_W-1:0]  answer,
   output logic [SCORE_W-1:0] strike,
   output logic [SCORE_W-1:0] ball
);

   // Same digit in the same position is a strike; in a different position it is a ball.
   always_comb begin
      strike = '0;
      ball   = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (guess[DIGIT_W*i +: DIGIT_W] == answer[DIGIT_W*j +: DIGIT_W]) begin
               if (i == j) strike = strike + 4'd1;
               else        ball   = ball + 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bc_game_ctrl.sv
// Bulls-and-Cows round controller: latches the answer, accepts and scores guesses,
// counts attempts and reports win/loss.
module bc_game_ctrl
   import bc_pkg::*;
#(
   parameter int unsigned MAX_TRIES  = 10,
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            abort,
   input  logic [NUM_DIGITS*DIGIT_W-1:0]   answer_in,
   input  logic                            guess_valid,
   input  logic [NUM_DIGITS*DIGIT_W-1:0]   guess,
   output logic                            guess_ready,
   output logic                            result_valid,
   output logic [SCORE_W-1:0]              res_strike,
   output logic [SCORE_W-1:0]              res_ball,
   output logic                            guess_err,
   output logic                            ans_err,
   output logic [3:0]                      tries,
   output logic                            game_won,
   output logic                            game_over,
   output logic [2:0]                      state_o
);

   localparam logic [3:0] MaxTries = 4'(MAX_TRIES);

   state_t              state_q, state_d;
   logic [CODE_W-1:0]   answer_q, guess_q;
   logic [3:0]          tries_q, tries_inc;
   logic [SCORE_W-1:0]  res_strike_q, res_ball_q;
   logic [SCORE_W-1:0]  sc_strike, sc_ball;
   logic                result_valid_q, guess_err_q, ans_err_q;
   logic                answer_ok, guess_ok, handshake;
   logic                load_game, take_guess, do_score, bad_guess, bad_start;

   bc_score u_score (
      .guess  (guess_q),
      .answer (answer_q),
      .strike (sc_strike),
      .ball   (sc_ball)
   );

   assign answer_ok = code_legal(answer_in);
   assign guess_ok  = code_legal(guess);
   assign tries_inc = tries_q + 4'd1;

   // Abort blocks the handshake so a guess is never half-taken while the game is torn down.
   assign guess_ready = (state_q == ST_PLAY) & ~abort;
   assign handshake   = guess_valid & guess_ready;

   // Next-state and per-cycle update strobes; abort overrides everything.
   always_comb begin
      state_d    = state_q;
      load_game  = 1'b0;
      take_guess = 1'b0;
      do_score   = 1'b0;
      bad_guess  = 1'b0;
      bad_start  = 1'b0;
      case (state_q)
         ST_IDLE, ST_WIN, ST_LOSE: begin
            if (start) begin
               if (answer_ok) begin
                  load_game = 1'b1;
                  state_d   = ST_PLAY;
               end else begin
                  bad_start = 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (handshake) begin
               if (guess_ok) begin
                  take_guess = 1'b1;
                  state_d    = ST_SCORE;
               end else begin
                  bad_guess = 1'b1;
               end
            end
         end
         ST_SCORE: begin
            do_score = 1'b1;
            if (sc_strike == 4'd4)         state_d = ST_WIN;
            else if (tries_inc == MaxTries) state_d = ST_LOSE;
            else                            state_d = ST_PLAY;
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort) begin
         state_d    = ST_IDLE;
         load_game  = 1'b0;
         take_guess = 1'b0;
         do_score   = 1'b0;
         bad_guess  = 1'b0;
         bad_start  = 1'b0;
      end
   end

   // State, game data and registered result/error pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         answer_q       <= '0;
         guess_q        <= '0;
         tries_q        <= '0;
         res_strike_q   <= '0;
         res_ball_q     <= '0;
         result_valid_q <= 1'b0;
         guess_err_q    <= 1'b0;
         ans_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         result_valid_q <= do_score;
         guess_err_q    <= bad_guess;
         ans_err_q      <= bad_start;
         if (load_game) begin
            answer_q     <= answer_in;
            tries_q      <= '0;
            res_strike_q <= '0;
            res_ball_q   <= '0;
         end
         if (take_guess) guess_q <= guess;
         if (do_score) begin
            res_strike_q <= sc_strike;
            res_ball_q   <= sc_ball;
            tries_q      <= tries_inc;
         end
         if (abort) tries_q <= '0;
      end
   end

   assign result_valid = result_valid_q;
   assign res_strike   = res_strike_q;
   assign res_ball     = res_ball_q;
   assign guess_err    = guess_err_q;
   assign ans_err      = ans_err_q;
   assign tries        = tries_q;
   assign game_won     = (state_q == ST_WIN);
   assign game_over    = (state_q == ST_WIN) | (state_q == ST_LOSE);
   assign state_o      = state_q;

endmodule

// File: tb/tb_bc_game_ctrl.sv
// Directed self-checking bench for bc_game_ctrl (MAX_TRIES = 3).
module tb_bc_game_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, abort, guess_valid;
   logic [15:0] answer_in, guess;
   logic        guess_ready, result_valid, guess_err, ans_err, game_won, game_over;
   logic [3:0]  res_strike, res_ball, tries;
   logic [2:0]  state_o;

   int checks = 0;
   int errors = 0;

   bc_game_ctrl #(.MAX_TRIES(3), .NUM_DIGITS(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .answer_in    (answer_in),
      .guess_valid  (guess_valid),
      .guess        (guess),
      .guess_ready  (guess_ready),
      .result_valid (result_valid),
      .res_strike   (res_strike),
      .res_ball     (res_ball),
      .guess_err    (guess_err),
      .ans_err      (ans_err),
      .tries        (tries),
      .game_won     (game_won),
      .game_over    (game_over),
      .state_o      (state_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; guess_valid = 1'b0;
      answer_in = '0; guess = '0;
      #12;
      check("rst_state", 16'(state_o), 16'd0);
      check("rst_ready", 16'(guess_ready), 16'd0);
      check("rst_flags", {12'd0, result_valid, guess_err, ans_err, game_over}, 16'd0);
      rst_n = 1'b1;
      tick();

      // Game 1: answer 1234, guess 4321 -> 0 strikes, 4 balls
      start = 1'b1; answer_in = 16'h1234;
      tick();
      start = 1'b0;
      check("g1_play", 16'(state_o), 16'd1);
      check("g1_ready", 16'(guess_ready), 16'd1);
      guess_valid = 1'b1; guess = 16'h4321;
      tick();
      guess_valid = 1'b0;
      check("g1_score_state", 16'(state_o), 16'd2);
      check("g1_score_rv", 16'(result_valid), 16'd0);
      check("g1_score_ready", 16'(guess_ready), 16'd0);
      tick();
      check("g1_rv", 16'(result_valid), 16'd1);
      check("g1_sb", {8'd0, res_strike, res_ball}, 16'h0004);
      check("g1_tries", 16'(tries), 16'd1);
      check("g1_state", 16'(state_o), 16'd1);
      tick();
      check("g1_rv_pulse", 16'(result_valid), 16'd0);
      check("g1_start_ignored_pre", 16'(state_o), 16'd1);

      // Abort back to IDLE
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle", 16'(state_o), 16'd0);
      check("abort_tries", 16'(tries), 16'd0);

      // Illegal answer in IDLE
      start = 1'b1; answer_in = 16'h5565;
      tick();
      start = 1'b0;
      check("idle_anserr", 16'(ans_err), 16'd1);
      check("idle_anserr_state", 16'(state_o), 16'd0);
      tick();
      check("idle_anserr_pulse", 16'(ans_err), 16'd0);

      // Game 2: illegal guesses, then win in two tries
      start = 1'b1; answer_in = 16'h1234;
      tick();
      start = 1'b0;
      guess_valid = 1'b1; guess = 16'h1123;
      tick();
      check("dup_gerr", 16'(guess_err), 16'd1);
      check("dup_state", 16'(state_o), 16'd1);
      guess = 16'h12A4;
      tick();
      guess_valid = 1'b0;
      check("bcd_gerr", 16'(guess_err), 16'd1);
      check("bcd_rv", 16'(result_valid), 16'd0);
      tick();
      check("gerr_pulse", 16'(guess_err), 16'd0);
      check("gerr_tries", 16'(tries), 16'd0);
      guess_valid = 1'b1; guess = 16'h1243;
      tick();
      guess_valid = 1'b0;
      tick();
      check("g2a_rv", 16'(result_valid), 16'd1);
      check("g2a_sb", {8'd0, res_strike, res_ball}, 16'h0022);
      guess_valid = 1'b1; guess = 16'h1234;
      tick();
      guess_valid = 1'b0;
      tick();
      check("g2b_sb", {8'd0, res_strike, res_ball}, 16'h0040);
      check("g2b_state", 16'(state_o), 16'd3);
      check("g2b_won_over", {14'd0, game_won, game_over}, 16'h0003);
      check("g2b_tries", 16'(tries), 16'd2);
      check("g2b_ready", 16'(guess_ready), 16'd0);
      guess_valid = 1'b1; guess = 16'h1123;
      tick();
      guess_valid = 1'b0;
      check("win_guess_ignored", 16'(guess_err), 16'd0);
      start = 1'b1; answer_in = 16'h5565;
      tick();
      start = 1'b0;
      check("win_anserr", 16'(ans_err), 16'd1);
      check("win_stays", 16'(state_o), 16'd3);

      // Game 3: answer 0987, three misses -> LOSE
      start = 1'b1; answer_in = 16'h0987;
      tick();
      start = 1'b0;
      check("g3_play", 16'(state_o), 16'd1);
      check("g3_tries0", 16'(tries), 16'd0);
      check("g3_won_cleared", 16'(game_won), 16'd0);
      for (int i = 1; i <= 3; i++) begin
         guess_valid = 1'b1; guess = 16'h1234;
         tick();
         guess_valid = 1'b0;
         tick();
         check("g3_rv", 16'(result_valid), 16'd1);
         check("g3_sb", {8'd0, res_strike, res_ball}, 16'h0000);
         check("g3_tries", 16'(tries), 16'(i));
      end
      check("g3_lose", 16'(state_o), 16'd4);
      check("g3_won_over", {14'd0, game_won, game_over}, 16'h0001);
      start = 1'b1; answer_in = 16'h5565;
      tick();
      check("lose_anserr", 16'(ans_err), 16'd1);
      check("lose_stays", 16'(state_o), 16'd4);
      answer_in = 16'h5678;
      tick();
      start = 1'b0;
      check("lose_restart", 16'(state_o), 16'd1);
      check("lose_restart_tries", 16'(tries), 16'd0);

      // Abort during SCORE suppresses the result
      guess_valid = 1'b1; guess = 16'h5687;
      tick();
      guess_valid = 1'b0;
      check("abs_score", 16'(state_o), 16'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abs_rv", 16'(result_valid), 16'd0);
      check("abs_state", 16'(state_o), 16'd0);
      check("abs_tries", 16'(tries), 16'd0);

      // Reset mid-PLAY
      start = 1'b1; answer_in = 16'h1234;
      tick();
      start = 1'b0;
      guess_valid = 1'b1; guess = 16'h4321;
      tick();
      guess_valid = 1'b0;
      tick();
      check("pre_rst_tries", 16'(tries), 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_state", 16'(state_o), 16'd0);
      check("mid_rst_tries", 16'(tries), 16'd0);
      check("mid_rst_sb", {8'd0, res_strike, res_ball}, 16'h0000);
      check("mid_rst_flags", {11'd0, guess_ready, result_valid, guess_err, ans_err, game_over},
            16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bc_game_ctrl.md
Name: bc_game_ctrl

Overview:
Round controller for the Bulls-and-Cows game. Latches a secret answer and accepts player guesses over a valid/ready handshake. Checks that every guess is legal, then scores it with a combinational strike/ball scorer and registers the result. Counts attempts and declares win or loss. Sits between the input/keypad front end and the LCD/status display logic.

Parameters:
MAX_TRIES, 10, scored guesses allowed per game (1..15)
NUM_DIGITS, 4, BCD digits per code; fixed at 4 in this version (16-bit codes)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: load answer_in and begin a game
abort  in  1  pulse: abandon the current game and return to IDLE
answer_in  in  16  secret code; digit i = bits [4i+3:4i]
guess_valid  in  1  guess presented
guess  in  16  guess code, same digit layout as answer_in
guess_ready  out  1  controller accepts a guess this cycle
result_valid  out  1  one-cycle pulse: res_* updated
res_strike  out  4  strikes of the last scored guess
res_ball  out  4  balls of the last scored guess
guess_err  out  1  one-cycle pulse: guess rejected as illegal
ans_err  out  1  one-cycle pulse: start refused because answer_in is illegal
tries  out  4  number of scored guesses in the current game
game_won  out  1  level; high in the WIN state
game_over  out  1  level; high in the WIN or LOSE state
state_o  out  3  current FSM state, for the display logic

Behaviour:
- Reset (async assert, sync deassert at the next clk edge): state IDLE; every output 0.
- Legal code: each digit is in 0..9 and all four digits are pairwise distinct. The legality check is combinational.
- FSM states: IDLE=0, PLAY=1, SCORE=2, WIN=3, LOSE=4.
- IDLE:
  - start with a legal answer_in: latch the answer, clear tries and res_*, go to PLAY.
  - start with an illegal answer_in: pulse ans_err, stay in IDLE.
- PLAY:
  - guess_ready=1. A handshake is guess_valid & guess_ready.
  - Illegal guess: pulse guess_err in the next cycle; tries unchanged; stay in PLAY.
  - Legal guess: register the guess, go to SCORE.
- SCORE (exactly 1 cycle, guess_ready=0):
  - Register the scorer output into res_strike and res_ball, increment tries, pulse result_valid.
  - Next state: WIN if strike==4; else LOSE if the new tries==MAX_TRIES; else PLAY.
  - Latency: handshake in cycle N, result_valid in cycle N+2; the next guess can be accepted in cycle N+2.
- WIN/LOSE:
  - Outputs hold; guess_ready=0. game_won=1 only in WIN.
  - start with a legal answer: begin a new game directly (PLAY, tries=0).
  - start with an illegal answer: pulse ans_err and stay.
- Scoring: strike = positions where guess digit equals answer digit. ball = pairs (i,j), i≠j, with guess[i]==answer[j]. Both are 4-bit; max 4 because digits are distinct, so strike+ball ≤ 4.
- abort has priority over everything except reset. From any state it goes to IDLE, clears tries, game_won and game_over, and suppresses any result_valid or guess_err pulse for that cycle. res_* hold their last value.
- start while in PLAY or SCORE is ignored.
- start and abort in the same cycle: abort wins.
- guess_valid outside PLAY is ignored and produces no error pulse.
- tries never exceeds MAX_TRIES; there is no wrap.
- Reset asserted mid-game: immediate return to IDLE with all outputs 0.

Decomposition:
- Shared package bc_pkg holds:
  - state encoding constants ST_IDLE..ST_LOSE;
  - DIGIT_W=4, CODE_W=16, SCORE_W=4;
  - function code_legal (digit range and distinctness check).
- One natural sub-module: bc_score, a combinational scorer with inputs guess[15:0] and answer[15:0] and outputs strike[3:0] and ball[3:0]. It is instantiated on the registered guess and the latched answer.

Test Plan:
- Reset, then start, answer 0x1234, guess 0x4321 -> result_valid 2 cycles after the handshake; strike=0, ball=4, tries=1, state PLAY.
- Answer 0x1234, guess 0x1243 then guess 0x1234 -> strike=2/ball=2, then strike=4/ball=0; game_won=1, game_over=1, tries=2; guess_ready=0 afterwards.
- Guess 0x1123 (duplicate digit), then 0x12A4 (digit >9) -> two guess_err pulses, no result_valid, tries stays 0.
- MAX_TRIES=3, answer 0x0987, three legal misses of 0x1234 -> strike=0, ball=0 each; after the third, state LOSE, game_over=1, game_won=0.
- start with answer_in 0x5565 in IDLE -> ans_err pulse, state IDLE. Then start with 0x5678 in LOSE -> PLAY with tries=0.
- abort asserted in the SCORE cycle -> no result_valid, state IDLE, tries=0. Then rst_n low mid-PLAY -> all outputs 0 asynchronously.
